tdc_multichannel: RTL and testbench

//  Parametrised successor to the 2-channel TDC: time-interval measurement across N_CH photon-pulse

---
 rtl/tdc_multichannel.sv | 193 +++++++++++++++++++
 tb/tb_tdc_multichannel.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/tdc_multichannel.sv
// Multichannel TDC: per-channel synchroniser and edge detect, start/stop/timeout FSM, FWFT event FIFO.
// Latency: edge seen 3 cycles after pulse rise, event visible 1 cycle after capture; ev_ready low fills FIFO, then drops and counts events.

module tdc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld_i,
  output logic             wr_rdy_o,
  input  logic [WIDTH-1:0] wr_dat_i,
  output logic             rd_vld_o,
  input  logic             rd_rdy_i,
  output logic [WIDTH-1:0] rd_dat_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] hold_q;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             push, pop, full;

  assign full     = (cnt_q == (AW+1)'(DEPTH));
  assign rd_vld_o = (cnt_q != '0);
  assign pop      = rd_vld_o & rd_rdy_i;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign wr_rdy_o = ~full | pop;
  assign push     = wr_vld_i & wr_rdy_o;
  assign rd_dat_o = rd_vld_o ? mem_q[rd_ptr_q] : hold_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      hold_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wr_dat_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        hold_q   <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

module tdc_multichannel #(
  parameter int N_CH       = 2,
  parameter int CNT_W      = 7,
  parameter int MAX_WINDOW = 100,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  pulse,
  input  logic             enable,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [N_CH-1:0]  ev_start,
  output logic [N_CH-1:0]  ev_end,
  output logic [CNT_W-1:0] ev_interval,
  output logic             ev_timeout,
  output logic [15:0]      overflow_cnt
);
  typedef struct packed {
    logic [N_CH-1:0]  start;
    logic [N_CH-1:0]  stop;
    logic [CNT_W-1:0] interval;
    logic             timeout;
  } ev_t;

  typedef enum logic {IDLE, ARMED} state_t;

  localparam logic [N_CH-1:0]  ONE_CH = 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WINDOW);

  logic [N_CH-1:0]  sync1_q, sync2_q, sync3_q, rise_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0]  start_q, start_d;
  logic [15:0]      ovf_q, ovf_d;
  logic             push_vld, push_rdy, any_rise, multi_rise;
  ev_t              push_dat, head;

  // sync3 resets low so a level already high at reset release reads as a rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      rise_q  <= '0;
    end else begin
      sync1_q <= pulse;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      rise_q  <= sync2_q & ~sync3_q;
    end
  end

  assign any_rise   = |rise_q;
  assign multi_rise = |(rise_q & (rise_q - ONE_CH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      start_q <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    start_d  = start_q;
    push_vld = 1'b0;
    push_dat = '0;
    case (state_q)
      IDLE: begin
        if (enable && any_rise) begin
          if (multi_rise) begin
            push_vld = 1'b1;
            push_dat = '{start: rise_q, stop: rise_q, interval: '0, timeout: 1'b0};
          end else begin
            start_d = rise_q;
            cnt_d   = CNT_W'(1);
            state_d = ARMED;
          end
        end
      end
      ARMED: begin
        if (!enable) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (any_rise) begin
          push_vld = 1'b1;
          push_dat = '{start: start_q, stop: rise_q, interval: cnt_q, timeout: 1'b0};
          cnt_d    = '0;
          state_d  = IDLE;
        end else if (cnt_q == MAX_CNT) begin
          push_vld = 1'b1;
          push_dat = '{start: start_q, stop: '0, interval: MAX_CNT, timeout: 1'b1};
          cnt_d    = '0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (push_vld && !push_rdy && ovf_q != 16'hFFFF) ovf_d = ovf_q + 1'b1;
  end

  tdc_fifo #(
    .WIDTH($bits(ev_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_vld_i (push_vld),
    .wr_rdy_o (push_rdy),
    .wr_dat_i (push_dat),
    .rd_vld_o (ev_valid),
    .rd_rdy_i (ev_ready),
    .rd_dat_o (head)
  );

  assign ev_start     = head.start;
  assign ev_end       = head.stop;
  assign ev_interval  = head.interval;
  assign ev_timeout   = head.timeout;
  assign overflow_cnt = ovf_q;
endmodule

// File: tb/tb_tdc_multichannel.sv
// Bench for tdc_multichannel: timestamp-based event model feeds a scoreboard, negedge monitor compares.
module tb_tdc_multichannel;
  localparam int N_CH = 2;
  localparam int CNT_W = 7;
  localparam int MAXW = 100;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N_CH-1:0]  pulse = '0;
  logic             enable = 1'b0;
  logic             ev_ready = 1'b1;
  logic             ev_valid;
  logic [N_CH-1:0]  ev_start, ev_end;
  logic [CNT_W-1:0] ev_interval;
  logic             ev_timeout;
  logic [15:0]      overflow_cnt;

  tdc_multichannel #(.N_CH(N_CH), .CNT_W(CNT_W), .MAX_WINDOW(MAXW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pulse(pulse), .enable(enable),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_start(ev_start), .ev_end(ev_end),
    .ev_interval(ev_interval), .ev_timeout(ev_timeout), .overflow_cnt(overflow_cnt)
  );

  always #5 clk = ~clk;

  typedef logic [2*N_CH+CNT_W:0] ev_t;  // {start, end, interval, timeout}

  ev_t             expq[$];
  int              vectors = 0, miscompares = 0;
  int              occ = 0, ovf = 0;
  bit              armed = 0;
  longint          cyc = 0, ts = 0;
  logic [N_CH-1:0] smask = '0;
  logic [N_CH-1:0] hist [4] = '{default: '0};

  task automatic model_push(input ev_t e, input bit pop);
    if (occ < DEPTH || pop) begin
      expq.push_back(e);
      occ++;
    end else if (ovf < 65535) begin
      ovf++;
    end
  endtask

  // Reference: edges are pulse rises seen through a fixed pipeline delay; intervals are timestamp differences.
  always @(posedge clk or posedge rst) begin : model
    logic [N_CH-1:0] e;
    bit pop, pushed;
    if (rst) begin
      occ = 0; ovf = 0; armed = 0; cyc = 0;
      hist = '{default: '0};
      expq.delete();
    end else begin
      cyc++;
      e = hist[2] & ~hist[3];
      hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = pulse;
      pop = (occ > 0) && ev_ready;
      pushed = 0;
      if (!armed) begin
        if (enable && e != 0) begin
          if ($countones(e) >= 2) begin
            model_push({e, e, CNT_W'(0), 1'b0}, pop);
            pushed = 1;
          end else begin
            armed = 1; ts = cyc; smask = e;
          end
        end
      end else if (!enable) begin
        armed = 0;
      end else if (e != 0) begin
        model_push({smask, e, CNT_W'(cyc - ts), 1'b0}, pop);
        armed = 0;
      end else if (cyc - ts == MAXW) begin
        model_push({smask, {N_CH{1'b0}}, CNT_W'(MAXW), 1'b1}, pop);
        armed = 0;
      end
      if (pop) occ--;
    end
  end

  bit started = 0;

  always @(negedge clk) begin : monitor
    ev_t act, exp_e;
    if (started && !rst) begin
      vectors++;
      if (ev_valid !== (occ > 0)) begin
        miscompares++;
        $display("FAIL ev_valid t=%0t: got %b want %b", $time, ev_valid, occ > 0);
      end
      vectors++;
      if (overflow_cnt !== 16'(ovf)) begin
        miscompares++;
        $display("FAIL overflow_cnt t=%0t: got %0d want %0d", $time, overflow_cnt, ovf);
      end
      if (ev_valid && ev_ready) begin
        act = {ev_start, ev_end, ev_interval, ev_timeout};
        vectors++;
        if (expq.size() == 0) begin
          miscompares++;
          $display("FAIL event t=%0t: got unexpected %h want none", $time, act);
        end else begin
          exp_e = expq.pop_front();
          if (act !== exp_e) begin
            miscompares++;
            $display("FAIL event t=%0t: got start=%b end=%b iv=%0d to=%b want start=%b end=%b iv=%0d to=%b",
                     $time, ev_start, ev_end, ev_interval, ev_timeout,
                     exp_e[2*N_CH+CNT_W -: N_CH], exp_e[N_CH+CNT_W -: N_CH], exp_e[CNT_W:1], exp_e[0]);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pls(input logic [N_CH-1:0] m);
    pulse = m;
    tick(1);
    pulse = '0;
  endtask

  task automatic chk_reset(input string nm, input logic [63:0] got);
    vectors++;
    if (got !== 64'd0) begin
      miscompares++;
      $display("FAIL %s: got %0h want 0", nm, got);
    end
  endtask

  initial begin
    tick(3);
    @(negedge clk);
    chk_reset("reset ev_valid", 64'(ev_valid));
    chk_reset("reset ev_start", 64'(ev_start));
    chk_reset("reset ev_end", 64'(ev_end));
    chk_reset("reset ev_interval", 64'(ev_interval));
    chk_reset("reset ev_timeout", 64'(ev_timeout));
    chk_reset("reset overflow_cnt", 64'(overflow_cnt));
    tick(1);
    rst = 0; enable = 1; started = 1;
    tick(4);

    pls(2'b01); tick(9); pls(2'b10); tick(8);                           // start ch0, stop ch1 +10
    pls(2'b10); tick(4); pls(2'b01); tick(6);                           // ch1 -> ch0 +5
    pls(2'b01); tick(6); pls(2'b01); tick(8);                           // ch0 -> ch0 +7
    pls(2'b01); tick(100); pls(2'b10); tick(6); pls(2'b01); tick(8);    // timeout, then new start
    pls(2'b01); tick(99); pls(2'b10); tick(8);                          // stop exactly at MAX_WINDOW
    pls(2'b11); tick(8);                                                // coincidence

    ev_ready = 0;                                                       // 6 events into depth-4 FIFO
    repeat (6) begin pls(2'b11); tick(2); end
    tick(6);
    ev_ready = 1; tick(10);

    pls(2'b01); tick(5); enable = 0; tick(2); enable = 1; tick(3);      // abort by enable
    pls(2'b01); tick(4); pls(2'b10); tick(8);
    pls(2'b01); tick(5); rst = 1; tick(2); rst = 0; tick(4);            // abort by reset
    pls(2'b10); tick(6); pls(2'b01); tick(8);
    pulse = 2'b01; rst = 1; tick(2); rst = 0; tick(3); pulse = 0; tick(12);  // level high at release

    for (int seg = 0; seg < 24; seg++) begin
      int dens, rdy;
      dens = (seg % 3 == 0) ? 300 : 10;
      rdy  = (seg % 4 == 1) ? 8 : 2;
      for (int c = 0; c < 150; c++) begin
        for (int ch = 0; ch < N_CH; ch++)
          if ($urandom_range(dens - 1) == 0) pulse[ch] = ~pulse[ch];
        ev_ready = ($urandom_range(rdy - 1) == 0) ? 1'b0 : 1'b1;
        enable   = ($urandom_range(79) == 0) ? 1'b0 : 1'b1;
        tick(1);
      end
    end

    pulse = '0; enable = 0; ev_ready = 1;
    tick(20);
    vectors++;
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d events left undelivered want 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
